// File: rtl/ex_stage.sv
// Execute stage: holds one decoded instruction, computes its ALU result or runs a
// 32-step restoring divider (built only when EX_DIV_EN is defined), and hands off to MEM.
module ex_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ID_to_EX_valid,
    output logic         EX_allow_in,
    input  logic [139:0] to_EX_data,
    input  logic         MEM_allow_in,
    output logic         EX_to_MEM_valid,
    output logic [103:0] to_MEM_data,
    output logic [6:0]   ex_hazard,
    output logic         ex_busy
);

    localparam int unsigned TO_EX_W  = 140;
    localparam int unsigned TO_MEM_W = 104;
    localparam int unsigned XLEN     = 32;

    logic [TO_EX_W-1:0]  payload;
    logic [TO_MEM_W-1:0] mem_payload;
    logic                ex_valid;
    logic                ready_go;

    logic [XLEN-1:0]     pc;
    logic [3:0]          alu_op;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic [XLEN-1:0]     rkd_value;
    logic                mem_we;
    logic                res_from_mem;
    logic [4:0]          dest;
    logic                gr_we;
    logic [XLEN-1:0]     alu_result;

    assign pc           = payload[139:108];
    assign alu_op       = payload[107:104];
    assign src1         = payload[103:72];
    assign src2         = payload[71:40];
    assign rkd_value    = payload[39:8];
    assign mem_we       = payload[7];
    assign res_from_mem = payload[6];
    assign dest         = payload[5:1];
    assign gr_we        = payload[0];

    // Payload is captured only on an accepted handshake; it deliberately has no reset.
    always_ff @(posedge clk) begin
        if (ID_to_EX_valid && EX_allow_in) begin
            payload <= to_EX_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
        end else if (EX_allow_in) begin
            ex_valid <= ID_to_EX_valid;
        end
    end

    assign EX_allow_in     = ~ex_valid | (ready_go & MEM_allow_in);
    assign EX_to_MEM_valid = ex_valid & ready_go;

    assign mem_payload = {pc, alu_result, rkd_value, mem_we, res_from_mem, dest, gr_we};
    assign to_MEM_data = mem_payload;
    assign ex_hazard   = {ex_valid & gr_we, res_from_mem, dest};

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    div_state_t      div_state;
    logic [4:0]      div_count;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] div_dsor;

    logic            is_div;
    logic            div_signed;
    logic            div_by_zero;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            take;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] div_result;

    assign is_div      = alu_op[3] & alu_op[2];
    assign div_signed  = ~alu_op[1];
    assign div_by_zero = (src2 == '0);

    assign mag1 = (div_signed && src1[31]) ? (~src1 + 32'd1) : src1;
    assign mag2 = (div_signed && src2[31]) ? (~src2 + 32'd1) : src2;

    // One restoring step: bring in the next dividend bit and subtract if it fits.
    assign shifted = {div_rem, div_quo[31]};
    assign diff    = {1'b0, shifted} - {2'b00, div_dsor};
    assign take    = ~diff[XLEN+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_state <= DIV_IDLE;
            div_count <= 5'd0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (ex_valid && is_div) begin
                        div_state <= DIV_BUSY;
                        div_count <= 5'd0;
                        div_quo   <= mag1;
                        div_rem   <= '0;
                        div_dsor  <= mag2;
                    end
                end
                DIV_BUSY: begin
                    div_quo   <= {div_quo[30:0], take};
                    div_rem   <= take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                    div_count <= 5'(div_count + 5'd1);
                    if (div_count == 5'd31) begin
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (ex_valid && MEM_allow_in) begin
                        div_state <= DIV_IDLE;
                    end
                end
                default: begin
                    div_state <= DIV_IDLE;
                end
            endcase
        end
    end

    // Sign correction from the held operands; divide-by-zero bypasses it entirely.
    always_comb begin
        quo_fix = div_quo;
        rem_fix = div_rem;
        if (div_signed && (src1[31] ^ src2[31])) begin
            quo_fix = ~div_quo + 32'd1;
        end
        if (div_signed && src1[31]) begin
            rem_fix = ~div_rem + 32'd1;
        end
        if (div_by_zero) begin
            quo_fix = '1;
            rem_fix = src1;
        end
        div_result = alu_op[0] ? rem_fix : quo_fix;
    end

    assign ready_go = ~is_div | (div_state == DIV_DONE);
    assign ex_busy  = (div_state == DIV_BUSY);
`else
    logic [XLEN-1:0] div_result;

    assign div_result = '0;
    assign ready_go   = 1'b1;
    assign ex_busy    = 1'b0;
`endif

    // Single-cycle ALU; divide opcodes select the divider output (zero when not built).
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'd0:  alu_result = src1 + src2;
            4'd1:  alu_result = src1 - src2;
            4'd2:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
            4'd3:  alu_result = {31'd0, src1 < src2};
            4'd4:  alu_result = src1 & src2;
            4'd5:  alu_result = src1 | src2;
            4'd6:  alu_result = ~(src1 | src2);
            4'd7:  alu_result = src1 ^ src2;
            4'd8:  alu_result = src1 << src2[4:0];
            4'd9:  alu_result = src1 >> src2[4:0];
            4'd10: alu_result = 32'($signed(src1) >>> src2[4:0]);
            4'd11: alu_result = src2;
            default: alu_result = div_result;
        endcase
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed test-plan cases, a mid-divide reset,
// and a randomized stream scored against an arithmetic reference model.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ID_to_EX_valid;
    logic         EX_allow_in;
    logic [139:0] to_EX_data;
    logic         MEM_allow_in;
    logic         EX_to_MEM_valid;
    logic [103:0] to_MEM_data;
    logic [6:0]   ex_hazard;
    logic         ex_busy;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef EX_DIV_EN
    localparam bit DIV_BUILT = 1'b1;
`else
    localparam bit DIV_BUILT = 1'b0;
`endif

    ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ID_to_EX_valid  (ID_to_EX_valid),
        .EX_allow_in     (EX_allow_in),
        .to_EX_data      (to_EX_data),
        .MEM_allow_in    (MEM_allow_in),
        .EX_to_MEM_valid (EX_to_MEM_valid),
        .to_MEM_data     (to_MEM_data),
        .ex_hazard       (ex_hazard),
        .ex_busy         (ex_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [103:0] got, input logic [103:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference results straight from the operation definitions, using 64-bit math.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'd0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  r = (a < b) ? 32'd1 : 32'd0;
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = ~(a | b);
            4'd7:  r = a ^ b;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = 32'(sa >>> b[4:0]);
            4'd11: r = b;
            default: begin
                if (DIV_BUILT) begin
                    if (b == 32'd0)     r = op[0] ? a : 32'hFFFF_FFFF;
                    else if (op == 12)  r = 32'(sa / sb);
                    else if (op == 13)  r = 32'(sa % sb);
                    else if (op == 14)  r = a / b;
                    else                r = a % b;
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    logic [31:0] t_pc, t_rkd;
    logic [4:0]  t_dest;
    logic        t_we, t_rfm, t_gw;

    function automatic logic [139:0] mk_in(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        return {t_pc, op, a, b, t_rkd, t_we, t_rfm, t_dest, t_gw};
    endfunction

    function automatic logic [103:0] mk_out(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        return {t_pc, ref_alu(op, a, b), t_rkd, t_we, t_rfm, t_dest, t_gw};
    endfunction

    task automatic rand_side();
        t_pc   = $urandom();
        t_rkd  = $urandom();
        t_dest = 5'($urandom_range(0, 31));
        t_we   = 1'($urandom_range(0, 1));
        t_rfm  = 1'($urandom_range(0, 1));
        t_gw   = 1'($urandom_range(0, 1));
    endtask

    // Issue one instruction into an empty stage, wait for it, optionally stall MEM.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic [103:0] exp;
        int lat;
        int exp_lat;
        rand_side();
        t_gw    = 1'b1;
        exp     = mk_out(op, a, b);
        exp_lat = (DIV_BUILT && op >= 12) ? 33 : 0;
        @(negedge clk);
        check({tag, ".allow_idle"}, 104'(EX_allow_in), 104'd1);
        ID_to_EX_valid = 1'b1;
        to_EX_data     = mk_in(op, a, b);
        MEM_allow_in   = (stall == 0);
        @(negedge clk);
        ID_to_EX_valid = 1'b0;
        to_EX_data     = {$urandom(), $urandom(), $urandom(), $urandom(), 12'($urandom())};
        check({tag, ".hazard"}, 104'(ex_hazard), 104'({1'b1, t_rfm, t_dest}));
        lat = 0;
        while (!EX_to_MEM_valid && lat < 100) begin
            if (lat == 0) check({tag, ".allow_wait"}, 104'(EX_allow_in), 104'd0);
            if (lat == 1) check({tag, ".busy"}, 104'(ex_busy), 104'd1);
            if (lat == 20) check({tag, ".hazard_busy"}, 104'(ex_hazard),
                                 104'({1'b1, t_rfm, t_dest}));
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 104'(lat), 104'(exp_lat));
        check({tag, ".data"}, to_MEM_data, exp);
        check({tag, ".busy_done"}, 104'(ex_busy), 104'd0);
        for (int k = 0; k < stall; k++) begin
            check({tag, ".allow_stall"}, 104'(EX_allow_in), 104'd0);
            check({tag, ".hold"}, to_MEM_data, exp);
            @(negedge clk);
        end
        MEM_allow_in = 1'b1;
        #1;
        check({tag, ".allow_xfer"}, 104'(EX_allow_in), 104'd1);
        @(negedge clk);
        check({tag, ".empty"}, 104'({EX_to_MEM_valid, ex_hazard[6]}), 104'd0);
    endtask

    logic [103:0] sb_q[$];
    logic [103:0] cur_exp;
    logic [103:0] got_exp;
    logic         took;

    initial begin
        reset          = 1'b1;
        ID_to_EX_valid = 1'b0;
        MEM_allow_in   = 1'b1;
        to_EX_data     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset.valid", 104'(EX_to_MEM_valid), 104'd0);
        check("reset.allow", 104'(EX_allow_in), 104'd1);
        check("reset.busy", 104'(ex_busy), 104'd0);
        check("reset.hazard", 104'(ex_hazard[6]), 104'd0);

        run_op("add", 4'd0, 32'd5, 32'hFFFF_FFFF, 0);
        run_op("sra_stall", 4'd10, 32'h8000_0000, 32'd4, 3);
        run_op("divw", 4'd12, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("modw", 4'd13, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divwu_z", 4'd14, 32'd100, 32'd0, 0);
        run_op("modwu_z", 4'd15, 32'd100, 32'd0, 0);
        run_op("divw_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("modw_ovf", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divw_stall", 4'd12, 32'd9, 32'd3, 4);
        run_op("slt", 4'd2, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sltu", 4'd3, 32'hFFFF_FFFF, 32'd1, 0);

        // Reset in the middle of a divide.
        rand_side();
        t_gw = 1'b1;
        @(negedge clk);
        ID_to_EX_valid = 1'b1;
        to_EX_data     = mk_in(4'd12, 32'd1000, 32'd7);
        @(negedge clk);
        ID_to_EX_valid = 1'b0;
        repeat (11) @(negedge clk);
        if (DIV_BUILT) check("rst_mid.busy_before", 104'(ex_busy), 104'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid.busy", 104'(ex_busy), 104'd0);
        check("rst_mid.valid", 104'(EX_to_MEM_valid), 104'd0);
        check("rst_mid.allow", 104'(EX_allow_in), 104'd1);
        check("rst_mid.hazard", 104'(ex_hazard[6]), 104'd0);
        run_op("add_after_rst", 4'd0, 32'h1234_5678, 32'h1111_1111, 0);

        // Randomized stream with back-pressure; expected results queued in order.
        took = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!ID_to_EX_valid || took) begin
                if ($urandom_range(0, 2) != 0) begin
                    logic [3:0]  op;
                    logic [31:0] a, b;
                    op = ($urandom_range(0, 3) == 0) ? 4'(12 + $urandom_range(0, 3))
                                                      : 4'($urandom_range(0, 11));
                    a  = pick_operand();
                    b  = pick_operand();
                    rand_side();
                    to_EX_data     = mk_in(op, a, b);
                    cur_exp        = mk_out(op, a, b);
                    ID_to_EX_valid = 1'b1;
                end else begin
                    ID_to_EX_valid = 1'b0;
                end
            end
            took         = 1'b0;
            MEM_allow_in = ($urandom_range(0, 3) != 0);
            #1;
            if (EX_to_MEM_valid && MEM_allow_in) begin
                if (sb_q.size() == 0) begin
                    check("stream.spurious", 104'd1, 104'd0);
                end else begin
                    got_exp = sb_q.pop_front();
                    check("stream.data", to_MEM_data, got_exp);
                end
            end
            if (ID_to_EX_valid && EX_allow_in) begin
                sb_q.push_back(cur_exp);
                took = 1'b1;
            end
        end
        @(negedge clk);
        ID_to_EX_valid = 1'b0;
        MEM_allow_in   = 1'b1;
        for (int c = 0; c < 200 && sb_q.size() != 0; c++) begin
            #1;
            if (EX_to_MEM_valid) begin
                got_exp = sb_q.pop_front();
                check("drain.data", to_MEM_data, got_exp);
            end
            @(negedge clk);
        end
        check("drain.left", 104'(sb_q.size()), 104'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
